// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter time-sharing one single-cycle ALU
// Grants one requester per cycle and holds its ALU result in a one-entry response register.
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } ALUSel_e;
endpackage

module alu_share_arb #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [NUM_REQ-1:0]                i_req_valid,
   output logic [NUM_REQ-1:0]                o_req_ready,
   input  logic [NUM_REQ-1:0][31:0]          i_req_operand_a,
   input  logic [NUM_REQ-1:0][31:0]          i_req_operand_b,
   input  alu_pkg::ALUSel_e [NUM_REQ-1:0]    i_req_alu_op,
   output logic [31:0]                       o_alu_operand_a,
   output logic [31:0]                       o_alu_operand_b,
   output alu_pkg::ALUSel_e                  o_alu_op,
   input  logic [31:0]                       i_alu_res,
   output logic                              o_rsp_valid,
   input  logic                              i_rsp_ready,
   output logic [31:0]                       o_rsp_data,
   output logic [ID_W-1:0]                   o_rsp_id
);
   import alu_pkg::*;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] rr_next;
   logic [ID_W-1:0] winner;
   logic [ID_W:0]   scan_idx;
   logic            found;
   logic            slot_free;
   logic            grant;

   // A draining response frees the slot in the same cycle, giving one op per cycle.
   assign slot_free = !o_rsp_valid || i_rsp_ready;
   assign grant     = slot_free && found && !i_rst;

   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!found && i_req_valid[scan_idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[ID_W-1:0];
         end
      end
   end

   // Explicit wrap keeps the pointer off unused tags when NUM_REQ is not a power of two.
   always_comb begin
      if (winner == ID_W'(NUM_REQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = winner + ID_W'(1);
      end
   end

   always_comb begin
      o_req_ready     = '0;
      o_alu_operand_a = 32'd0;
      o_alu_operand_b = 32'd0;
      o_alu_op        = ALU_ADD;
      if (grant) begin
         o_req_ready     = NUM_REQ'(1) << winner;
         o_alu_operand_a = i_req_operand_a[winner];
         o_alu_operand_b = i_req_operand_b[winner];
         o_alu_op        = i_req_alu_op[winner];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= 32'd0;
         o_rsp_id    <= '0;
         rr_ptr      <= '0;
      end else if (grant) begin
         o_rsp_valid <= 1'b1;
         o_rsp_data  <= i_alu_res;
         o_rsp_id    <= winner;
         rr_ptr      <= rr_next;
      end else if (o_rsp_valid && i_rsp_ready) begin
         o_rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed scoreboard bench for alu_share_arb
// A behavioural ALU closes the loop; expected results are queued at grant and popped at response.
module tb_alu_share_arb;
   import alu_pkg::*;

   int checks = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input ALUSel_e op);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'd0;
      endcase
   endfunction

   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] opa;
   logic [1:0][31:0] opb;
   ALUSel_e [1:0]    ops;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   ALUSel_e          alu_op;
   logic [31:0]      alu_res;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [0:0]       rsp_id;

   assign alu_res = alu_f(alu_a, alu_b, alu_op);

   alu_share_arb #(.NUM_REQ(2)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_operand_a(opa), .i_req_operand_b(opb), .i_req_alu_op(ops),
      .o_alu_operand_a(alu_a), .o_alu_operand_b(alu_b), .o_alu_op(alu_op),
      .i_alu_res(alu_res),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_id(rsp_id)
   );

   logic             rst3;
   logic [2:0]       rv3;
   logic [2:0]       ready3;
   logic [2:0][31:0] opa3;
   logic [2:0][31:0] opb3;
   ALUSel_e [2:0]    ops3;
   logic [31:0]      alu_a3;
   logic [31:0]      alu_b3;
   ALUSel_e          alu_op3;
   logic [31:0]      alu_res3;
   logic             rsp_valid3;
   logic             rsp_ready3;
   logic [31:0]      rsp_data3;
   logic [1:0]       rsp_id3;

   assign alu_res3 = alu_f(alu_a3, alu_b3, alu_op3);

   alu_share_arb #(.NUM_REQ(3)) dut3 (
      .i_clk(clk), .i_rst(rst3),
      .i_req_valid(rv3), .o_req_ready(ready3),
      .i_req_operand_a(opa3), .i_req_operand_b(opb3), .i_req_alu_op(ops3),
      .o_alu_operand_a(alu_a3), .o_alu_operand_b(alu_b3), .o_alu_op(alu_op3),
      .i_alu_res(alu_res3),
      .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
      .o_rsp_data(rsp_data3), .o_rsp_id(rsp_id3)
   );

   int          m_ptr;
   bit          m_valid;
   logic [31:0] m_data;
   int          m_id;
   logic [34:0] sb_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of the 2-requester DUT, checked against the bench's own round-robin model.
   task automatic tick(input string tag);
      logic [1:0]  er;
      logic [34:0] e;
      bit          g;
      int          w;
      #1;
      g = 1'b0;
      w = 0;
      er = 2'b00;
      if (!rst && (!m_valid || rsp_ready)) begin
         for (int k = 0; k < 2; k++) begin
            if (!g && req_valid[(m_ptr + k) % 2]) begin
               g = 1'b1;
               w = (m_ptr + k) % 2;
            end
         end
      end
      if (g) er[w] = 1'b1;
      chk({tag, ".ready"}, 64'(req_ready), 64'(er));
      if (g) begin
         chk({tag, ".alu_a"}, 64'(alu_a), 64'(opa[w]));
         chk({tag, ".alu_op"}, 64'(alu_op), 64'(ops[w]));
         sb_q.push_back({3'(w), alu_f(opa[w], opb[w], ops[w])});
      end else begin
         chk({tag, ".alu_idle"}, {alu_a, 28'd0, alu_op}, {32'd0, 28'd0, ALU_ADD});
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1'b0;
         m_ptr = 0;
         m_data = 32'd0;
         m_id = 0;
         sb_q.delete();
      end else if (g) begin
         e = sb_q.pop_front();
         m_valid = 1'b1;
         m_ptr = (w + 1) % 2;
         m_data = e[31:0];
         m_id = int'(e[34:32]);
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
         chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(m_data));
         chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(m_id));
      end
   endtask

   initial begin
      int cnt[3];
      logic [2:0] e3;
      m_ptr = 0; m_valid = 1'b0; m_data = 32'd0; m_id = 0;
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
      opa = '0; opb = '0; ops = {ALU_ADD, ALU_ADD};
      rst3 = 1'b1; rv3 = 3'b000; rsp_ready3 = 1'b1;
      ops3 = {ALU_ADD, ALU_ADD, ALU_ADD};
      for (int i = 0; i < 3; i++) begin
         opa3[i] = 32'(i);
         opb3[i] = 32'd100;
      end

      tick("rst0");
      req_valid = 2'b01; opa[0] = 32'd5; opb[0] = 32'd3; ops[0] = ALU_ADD;
      tick("rst_req");
      chk("reset.data", 64'(rsp_data), 64'd0);
      chk("reset.id", 64'(rsp_id), 64'd0);

      // single op
      rst = 1'b0;
      tick("single");
      chk("single.data", 64'(rsp_data), 64'd8);
      req_valid = 2'b00;
      tick("single_drain");

      // contention from reset
      rst = 1'b1;
      tick("cont_rst");
      rst = 1'b0;
      opa[0] = 32'd0;    opb[0] = 32'd1;    ops[0] = ALU_SUB;
      opa[1] = 32'hF0;   opb[1] = 32'hFF;   ops[1] = ALU_XOR;
      req_valid = 2'b11;
      tick("cont0");
      chk("cont0.data", 64'(rsp_data), 64'hFFFF_FFFF);
      req_valid = 2'b10;
      tick("cont1");
      chk("cont1.data", 64'(rsp_data), 64'h0F);
      chk("cont1.id", 64'(rsp_id), 64'd1);

      // backpressure: four stalled cycles, then drain and grant together
      opa[0] = 32'd1;  opb[0] = 32'd2;  ops[0] = ALU_ADD;
      opa[1] = 32'd10; opb[1] = 32'd20; ops[1] = ALU_ADD;
      req_valid = 2'b11;
      tick("bp_first");
      req_valid = 2'b10; rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick("bp_hold");
      chk("bp.held_data", 64'(rsp_data), 64'd3);
      rsp_ready = 1'b1;
      tick("bp_release");
      chk("bp.release_data", 64'(rsp_data), 64'd30);
      chk("bp.release_valid", 64'(rsp_valid), 64'd1);

      // reset mid-stream with req1 pending behind a stalled response
      opa[1] = 32'd7; opb[1] = 32'd7; ops[1] = ALU_ADD;
      req_valid = 2'b10; rsp_ready = 1'b0;
      tick("mid_stall");
      rst = 1'b1;
      tick("mid_rst");
      chk("mid_rst.valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0; rsp_ready = 1'b1;
      tick("mid_req1_alone");
      chk("mid_req1_alone.id", 64'(rsp_id), 64'd1);
      rst = 1'b1;
      tick("mid_rst2");
      rst = 1'b0; req_valid = 2'b11;
      tick("mid_both");
      chk("mid_both.id", 64'(rsp_id), 64'd0);

      // arithmetic shift passthrough on requester 1
      opa[1] = 32'h8000_0000; opb[1] = 32'd4; ops[1] = ALU_SRA;
      req_valid = 2'b10;
      tick("sra");
      chk("sra.data", 64'(rsp_data), 64'hF800_0000);
      chk("sra.id", 64'(rsp_id), 64'd1);
      req_valid = 2'b00;
      tick("sra_drain");

      // fairness on a non-power-of-two instance
      for (int i = 0; i < 3; i++) cnt[i] = 0;
      @(posedge clk); #1;
      rst3 = 1'b0; rv3 = 3'b111;
      for (int c = 0; c < 9; c++) begin
         #1;
         e3 = 3'b001 << (c % 3);
         chk("fair.ready", 64'(ready3), 64'(e3));
         for (int i = 0; i < 3; i++) if (ready3[i]) cnt[i]++;
         @(posedge clk); #1;
         chk("fair.id", 64'(rsp_id3), 64'(c % 3));
         chk("fair.data", 64'(rsp_data3), 64'(100 + (c % 3)));
      end
      for (int i = 0; i < 3; i++) chk("fair.count", 64'(cnt[i]), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
